div_restoring_seq: RTL and testbench

Sequential signed 32-bit restoring divider serving the DIV instruction in the multicycle MIPS datapath. It sits between the A/B operand registers and the HI/LO register pair. Quotient feeds LO and remainder feeds HI. The control FSM pulses start, waits for done, then writes HI/LO or raises the divide-by-zero exception.

---
 rtl/div_restoring_seq_pkg.sv | 17 +
 rtl/div_restoring_seq_div_step.sv | 39 +++
 rtl/div_restoring_seq.sv | 129 ++++++++++++
 tb/tb_div_restoring_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH : default operand/result width
//   CNT_W     : iteration counter width for DIV_WIDTH
//   state_t   : controller state encoding (2-bit)
package div_restoring_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/div_restoring_seq_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   r      : partial remainder (WIDTH+1 bits)
//   q_msb  : dividend bit shifted into the remainder this step
//   d      : divisor magnitude
//   r_next : partial remainder after the trial subtraction/restore
//   q_bit  : quotient bit produced this step
module div_step
    import div_restoring_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] d_ext;
    logic           unused_r_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // never set going into a step; only the low WIDTH bits get shifted.
    assign unused_r_msb = r[WIDTH];
    assign trial        = {r[WIDTH-1:0], q_msb};
    assign d_ext        = {1'b0, d};

    always_comb begin
        r_next = trial;
        q_bit  = 1'b0;
        if (trial >= d_ext) begin
            r_next = trial - d_ext;
            q_bit  = 1'b1;
        end
    end

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential signed restoring divider (truncating, MIPS DIV semantics).
// Quotient goes to LO, remainder (sign of dividend) goes to HI.
// Ports:
//   clk         : clock, all state on rising edge
//   reset       : synchronous active-high reset
//   start       : request; accepted only in IDLE or DONE
//   a, b        : signed dividend / divisor, captured on acceptance
//   quotient    : signed quotient, registered, held until next completion
//   remainder   : signed remainder, registered, held until next completion
//   done        : one-cycle completion pulse
//   busy        : high in RUN and FINISH
//   div_by_zero : set with done when b was zero (results then held)
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for start
// S_RUN    | one restoring iteration per cycle, cnt counts down
// S_FINISH | apply signs, load quotient/remainder
// S_DONE   | done pulse cycle; a new start may be accepted here
module div_restoring_seq
    import div_restoring_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : ($clog2(WIDTH) + 1);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   r_next;
    logic             q_bit;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sign_q      <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r      <= a[WIDTH-1];
                        q_reg       <= abs_a;
                        d_reg       <= abs_b;
                        r_reg       <= '0;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (b == '0) begin
                            // Skip the iterations; results keep their old values.
                            state       <= S_DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_reg <= r_next;
                    q_reg <= {q_reg[WIDTH-2:0], q_bit};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    quotient  <= sign_q ? -q_reg : q_reg;
                    remainder <= sign_r ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed testbench for div_restoring_seq (WIDTH=32).
module tb_div_restoring_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int tests_run;
    int tests_failed;

    div_restoring_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one cycle; returns 1ns after the accepting edge.
    task automatic do_start(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done; edges counts clock edges since the call point.
    task automatic wait_done(output int edges, output int busy_cycles, output bit timed_out);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++; if (quotient !== 32'd0) begin tests_failed++; $display("FAIL reset_quotient got %h want %h", quotient, 32'd0); end
        tests_run++; if (remainder !== 32'd0) begin tests_failed++; $display("FAIL reset_remainder got %h want %h", remainder, 32'd0); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_basic;
        int e, bc; bit to;
        do_start(32'd7, 32'd2);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_accept got %b want 1", busy); end
        wait_done(e, bc, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout got no done want done"); end
        // done in the 34th cycle counting the start cycle = 33 edges after acceptance
        tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL basic_latency got %0d want 33", e); end
        tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
        tests_run++; if (quotient !== 32'd3) begin tests_failed++; $display("FAIL basic_quotient got %h want %h", quotient, 32'd3); end
        tests_run++; if (remainder !== 32'd1) begin tests_failed++; $display("FAIL basic_remainder got %h want %h", remainder, 32'd1); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
        @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_one_cycle got %b want 0", done); end
        tests_run++; if (quotient !== 32'd3) begin tests_failed++; $display("FAIL basic_quotient_hold got %h want %h", quotient, 32'd3); end
    endtask

    task automatic test_div_by_zero;
        int e, bc; bit to;
        do_start(32'd5, 32'd0);
        wait_done(e, bc, to);
        tests_run++; if (e !== 0 || to) begin tests_failed++; $display("FAIL dbz_latency got %0d want 0", e); end
        tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
        tests_run++; if (quotient !== 32'd3) begin tests_failed++; $display("FAIL dbz_quotient_held got %h want %h", quotient, 32'd3); end
        tests_run++; if (remainder !== 32'd1) begin tests_failed++; $display("FAIL dbz_remainder_held got %h want %h", remainder, 32'd1); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL dbz_busy got %b want 0", busy); end
        @(posedge clk);
        #1;
        tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag_hold got %b want 1", div_by_zero); end
        do_start(32'd9, 32'd4);
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL dbz_cleared_on_start got %b want 0", div_by_zero); end
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'd2 || remainder !== 32'd1) begin tests_failed++; $display("FAIL dbz_next_result got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd2, 32'd1); end
    endtask

    task automatic test_signs;
        int e, bc; bit to;
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL neg_a_quotient got %h want %h", quotient, 32'hFFFF_FFFD); end
        tests_run++; if (remainder !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL neg_a_remainder got %h want %h", remainder, 32'hFFFF_FFFF); end
        do_start(32'd7, 32'hFFFF_FFFE);
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL neg_b_quotient got %h want %h", quotient, 32'hFFFF_FFFD); end
        tests_run++; if (remainder !== 32'd1) begin tests_failed++; $display("FAIL neg_b_remainder got %h want %h", remainder, 32'd1); end
        do_start(32'hFFFF_FF9C, 32'hFFFF_FFF9); // -100 / -7
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'd14 || remainder !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL both_neg got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd14, 32'hFFFF_FFFE); end
    endtask

    task automatic test_overflow;
        int e, bc; bit to;
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'h8000_0000) begin tests_failed++; $display("FAIL ovf_quotient got %h want %h", quotient, 32'h8000_0000); end
        tests_run++; if (remainder !== 32'd0) begin tests_failed++; $display("FAIL ovf_remainder got %h want %h", remainder, 32'd0); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
        do_start(32'h8000_0000, 32'd1);
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'h8000_0000 || remainder !== 32'd0) begin tests_failed++; $display("FAIL minint_by_one got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'h8000_0000, 32'd0); end
        do_start(32'h7FFF_FFFF, 32'h8000_0000);
        wait_done(e, bc, to);
        tests_run++; if (to || quotient !== 32'd0 || remainder !== 32'h7FFF_FFFF) begin tests_failed++; $display("FAIL maxint_by_minint got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd0, 32'h7FFF_FFFF); end
    endtask

    task automatic test_back_to_back;
        int e, bc; bit to;
        do_start(32'd7, 32'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // 5 edges already elapsed since acceptance
        wait_done(e, bc, to);
        tests_run++; if (to || e !== 28) begin tests_failed++; $display("FAIL ignore_latency got %0d want 28", e); end
        tests_run++; if (quotient !== 32'd3 || remainder !== 32'd1) begin tests_failed++; $display("FAIL ignore_result got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd3, 32'd1); end
        do_start(32'd100, 32'd3);
        tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done); end
        a = 32'd55;
        b = 32'd0;
        wait_done(e, bc, to);
        tests_run++; if (to || e !== 33) begin tests_failed++; $display("FAIL b2b_latency got %0d want 33", e); end
        tests_run++; if (quotient !== 32'd33 || remainder !== 32'd1) begin tests_failed++; $display("FAIL b2b_result got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd33, 32'd1); end
    endtask

    task automatic test_reset_mid_run;
        int done_seen;
        do_start(32'd7, 32'd2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests_run++; if (quotient !== 32'd0 || remainder !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_outputs got q=%h r=%h want 0 0", quotient, remainder); end
        tests_run++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags got done=%b dbz=%b want 0 0", done, div_by_zero); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", done_seen); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_signs();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
